dac_update_scheduler: RTL and testbench

//   Shares one SPI transmitter (tx_start/tx_data/busy handshake) between two DAC-channel requesters (A, B) of an MCP482x DAC.

---
 rtl/dac_update_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_dac_update_scheduler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dac_update_scheduler.sv
// Shares one SPI transmitter between the two MCP482x DAC channels: round-robin grant,
// command word build, SPI start/busy handshake, guard delay and LDAC latch pulse.
module dac_update_scheduler #(
  parameter int LDAC_CYCLES  = 2,
  parameter int GUARD_CYCLES = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a,
  input  logic [11:0] code_a,
  input  logic        req_b,
  input  logic [11:0] code_b,
  input  logic        gain_x2,
  input  logic        shdn_n,
  input  logic        sync_mode,
  input  logic        spi_busy,
  output logic        spi_start,
  output logic [15:0] spi_data,
  output logic        ldac_n,
  output logic        ack_a,
  output logic        ack_b,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    GUARD     = 3'd4,
    LATCH     = 3'd5
  } state_t;

  // One counter serves the busy timeout, guard delay and latch width.
  localparam int CNT_M1 = (BUSY_TIMEOUT > LDAC_CYCLES) ? BUSY_TIMEOUT : LDAC_CYCLES;
  localparam int CNT_MAX = (CNT_M1 > GUARD_CYCLES) ? CNT_M1 : GUARD_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(BUSY_TIMEOUT - 1);
  localparam logic [CW-1:0] GD_LAST  = CW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
  localparam logic [CW-1:0] LD_LAST  = CW'(LDAC_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  function automatic logic [15:0] cmd_word(input logic ch, input logic gain_bit,
                                           input logic shdn_bit, input logic [11:0] code);
    return {ch, 1'b0, ~gain_bit, shdn_bit, code};
  endfunction

  state_t        state_r, state_s;
  logic          spi_start_r, spi_start_s;
  logic [15:0]   spi_data_r, spi_data_s;
  logic          ldac_n_r, ldac_n_s;
  logic          ack_a_r, ack_a_s, ack_b_r, ack_b_s;
  logic          timeout_err_r, timeout_err_s;
  logic          last_r, last_s;
  logic          cur_r, cur_s;
  logic          wr_a_r, wr_a_s, wr_b_r, wr_b_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          grant_b_s;

  // Next-state and next-output logic for the transfer sequencer.
  always_comb begin
    state_s       = state_r;
    spi_start_s   = 1'b0;
    spi_data_s    = spi_data_r;
    ldac_n_s      = ldac_n_r;
    ack_a_s       = 1'b0;
    ack_b_s       = 1'b0;
    timeout_err_s = timeout_err_r;
    last_s        = last_r;
    cur_s         = cur_r;
    wr_a_s        = wr_a_r;
    wr_b_s        = wr_b_r;
    cnt_s         = cnt_r;
    // last_r = 1 means B was served last, so A wins a tie.
    grant_b_s     = req_b & (~req_a | ~last_r);
    case (state_r)
      IDLE: begin
        if (req_a | req_b) begin
          spi_start_s = 1'b1;
          last_s      = grant_b_s;
          cur_s       = grant_b_s;
          state_s     = START;
          if (grant_b_s) begin
            ack_b_s    = 1'b1;
            spi_data_s = cmd_word(1'b1, gain_x2, shdn_n, code_b);
          end else begin
            ack_a_s    = 1'b1;
            spi_data_s = cmd_word(1'b0, gain_x2, shdn_n, code_a);
          end
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        cnt_s   = CNT_ZERO;
        state_s = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (spi_busy) begin
          state_s = WAIT_DONE;
        end else if (cnt_r == TO_LAST) begin
          timeout_err_s = 1'b1;
          state_s       = IDLE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      WAIT_DONE: begin
        if (!spi_busy) begin
          if (cur_r) begin
            wr_b_s = 1'b1;
          end else begin
            wr_a_s = 1'b1;
          end
          cnt_s   = CNT_ZERO;
          state_s = GUARD;
        end else begin
          state_s = WAIT_DONE;
        end
      end
      GUARD: begin
        if (cnt_r == GD_LAST) begin
          if (!sync_mode || (wr_a_r && wr_b_r)) begin
            ldac_n_s = 1'b0;
            cnt_s    = CNT_ZERO;
            state_s  = LATCH;
          end else begin
            state_s = IDLE;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      LATCH: begin
        if (cnt_r == LD_LAST) begin
          ldac_n_s = 1'b1;
          wr_a_s   = 1'b0;
          wr_b_s   = 1'b0;
          state_s  = IDLE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        ldac_n_s = 1'b1;
        state_s  = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      spi_start_r   <= 1'b0;
      spi_data_r    <= 16'h0000;
      ldac_n_r      <= 1'b1;
      ack_a_r       <= 1'b0;
      ack_b_r       <= 1'b0;
      timeout_err_r <= 1'b0;
      last_r        <= 1'b1;
      cur_r         <= 1'b0;
      wr_a_r        <= 1'b0;
      wr_b_r        <= 1'b0;
      cnt_r         <= CNT_ZERO;
    end else begin
      state_r       <= state_s;
      spi_start_r   <= spi_start_s;
      spi_data_r    <= spi_data_s;
      ldac_n_r      <= ldac_n_s;
      ack_a_r       <= ack_a_s;
      ack_b_r       <= ack_b_s;
      timeout_err_r <= timeout_err_s;
      last_r        <= last_s;
      cur_r         <= cur_s;
      wr_a_r        <= wr_a_s;
      wr_b_r        <= wr_b_s;
      cnt_r         <= cnt_s;
    end
  end

  assign spi_start   = spi_start_r;
  assign spi_data    = spi_data_r;
  assign ldac_n      = ldac_n_r;
  assign ack_a       = ack_a_r;
  assign ack_b       = ack_b_r;
  assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_dac_update_scheduler.sv
// Directed bench for dac_update_scheduler: scoreboard of expected command words,
// a small SPI transmitter model, and LDAC timing/width tracking.
module tb_dac_update_scheduler;

  logic        clk, rst;
  logic        req_a, req_b, gain_x2, shdn_n, sync_mode, spi_busy;
  logic [11:0] code_a, code_b;
  logic        spi_start, ldac_n, ack_a, ack_b, timeout_err;
  logic [15:0] spi_data;

  logic [15:0] sb [$];
  logic [15:0] exp_w;
  int checks, errors;
  int cyc, busy_fall_cyc, pulses, low_cnt, ldac_rise_cyc;
  int start_cyc, tmo_cyc, ack_a_cyc, rise_at_ack_b;
  logic prev_ldac, prev_tmo;
  logic spi_en, pend;
  int left;
  int p0;

  dac_update_scheduler dut (
    .clk(clk), .rst(rst), .req_a(req_a), .code_a(code_a), .req_b(req_b), .code_b(code_b),
    .gain_x2(gain_x2), .shdn_n(shdn_n), .sync_mode(sync_mode), .spi_busy(spi_busy),
    .spi_start(spi_start), .spi_data(spi_data), .ldac_n(ldac_n), .ack_a(ack_a),
    .ack_b(ack_b), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // SPI transmitter model: busy rises one cycle after start, stays high 6 cycles.
  always @(negedge clk) begin
    if (rst) begin
      spi_busy = 1'b0; pend = 1'b0; left = 0;
    end else if (pend) begin
      pend = 1'b0; spi_busy = 1'b1; left = 6;
    end else if (left > 0) begin
      left--;
      if (left == 0) begin
        spi_busy = 1'b0;
        busy_fall_cyc = cyc;
      end
    end else if (spi_start && spi_en) begin
      pend = 1'b1;
    end
  end

  // Monitor: scoreboard pops on each grant, requester drops req after ack, LDAC timing.
  always @(negedge clk) begin
    if (rst) begin
      prev_ldac = 1'b1; low_cnt = 0; prev_tmo = 1'b0;
    end else begin
      if (spi_start || ack_a || ack_b) begin
        chk("ack_one_hot", 32'(ack_a & ack_b), 32'd0);
        chk("start_with_ack", 32'(spi_start), 32'(ack_a | ack_b));
        chk("busy_at_start", 32'(spi_busy), 32'd0);
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          exp_w = sb.pop_front();
          chk("spi_data", 32'(spi_data), 32'(exp_w));
          chk("ack_b_chan", 32'(ack_b), 32'(exp_w[15]));
        end
        start_cyc = cyc;
        if (ack_a) begin ack_a_cyc = cyc; req_a = 1'b0; end
        if (ack_b) begin rise_at_ack_b = ldac_rise_cyc; req_b = 1'b0; end
      end
      if (!ldac_n) begin
        if (prev_ldac) begin
          pulses++;
          low_cnt = 1;
          chk("ldac_delay", cyc - busy_fall_cyc, 32'd5);
        end else begin
          low_cnt++;
        end
      end else if (!prev_ldac) begin
        chk("ldac_width", low_cnt, 32'd2);
        ldac_rise_cyc = cyc;
      end
      prev_ldac = ldac_n;
      if (timeout_err && !prev_tmo) tmo_cyc = cyc;
      prev_tmo = timeout_err;
    end
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic request(input logic ch, input logic [11:0] code, input logic [15:0] expw);
    sb.push_back(expw);
    if (ch) begin code_b = code; req_b = 1'b1; end
    else begin code_a = code; req_a = 1'b1; end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && sb.size() != 0; i++) step();
    chk(tag, 32'(sb.size()), 32'd0);
    repeat (30) step();
  endtask

  task automatic pulse_rst();
    @(negedge clk); #2 rst = 1'b1;
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; pulses = 0; busy_fall_cyc = 0; ldac_rise_cyc = 0;
    low_cnt = 0; prev_ldac = 1'b1; prev_tmo = 1'b0; spi_en = 1'b1; pend = 1'b0; left = 0;
    start_cyc = 0; tmo_cyc = 0; ack_a_cyc = 0; rise_at_ack_b = 0;
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; code_a = 12'h000; code_b = 12'h000;
    gain_x2 = 1'b0; shdn_n = 1'b1; sync_mode = 1'b0; spi_busy = 1'b0;
    repeat (2) step();
    chk("rst_spi_start", 32'(spi_start), 32'd0);
    chk("rst_spi_data", 32'(spi_data), 32'd0);
    chk("rst_ldac_n", 32'(ldac_n), 32'd1);
    chk("rst_acks", 32'({ack_a, ack_b}), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    @(negedge clk); #2 rst = 1'b0;
    step();

    // Both held after reset: A first, then B.
    gain_x2 = 1'b1; shdn_n = 1'b1; p0 = pulses;
    request(1'b0, 12'h111, 16'h1111);
    request(1'b1, 12'h222, 16'h9222);
    drain("arb_drain");
    chk("arb_pulses", pulses - p0, 32'd2);

    // Single A transfer.
    gain_x2 = 1'b0; shdn_n = 1'b1; p0 = pulses;
    request(1'b0, 12'hABC, 16'h3ABC);
    drain("single_drain");
    chk("single_pulses", pulses - p0, 32'd1);

    // Both held after an A grant: B first.
    gain_x2 = 1'b0; shdn_n = 1'b0; p0 = pulses;
    request(1'b0, 12'h5A5, 16'h25A5);
    request(1'b1, 12'hA5A, 16'hAA5A);
    sb.delete();
    sb.push_back(16'hAA5A);
    sb.push_back(16'h25A5);
    drain("arb2_drain");
    chk("arb2_pulses", pulses - p0, 32'd2);

    // Sync mode: latch only once both channels written, flags clear afterwards.
    sync_mode = 1'b1; gain_x2 = 1'b1; shdn_n = 1'b1; p0 = pulses;
    request(1'b0, 12'h123, 16'h1123);
    drain("sync_a_drain");
    chk("sync_a_pulses", pulses - p0, 32'd0);
    request(1'b1, 12'h456, 16'h9456);
    drain("sync_b_drain");
    chk("sync_b_pulses", pulses - p0, 32'd1);
    request(1'b0, 12'h7FF, 16'h17FF);
    drain("sync_a2_drain");
    chk("sync_a2_pulses", pulses - p0, 32'd1);
    request(1'b1, 12'h800, 16'h9800);
    drain("sync_b2_drain");
    chk("sync_b2_pulses", pulses - p0, 32'd2);
    sync_mode = 1'b0;

    // Busy never rises: timeout after BUSY_TIMEOUT cycles, no latch, next request served.
    gain_x2 = 1'b0; shdn_n = 1'b1; spi_en = 1'b0; p0 = pulses;
    request(1'b1, 12'h0F0, 16'hB0F0);
    for (int i = 0; i < 60 && !timeout_err; i++) step();
    chk("timeout_set", 32'(timeout_err), 32'd1);
    chk("timeout_delay", tmo_cyc - start_cyc, 32'd17);
    repeat (5) step();
    chk("timeout_no_latch", pulses - p0, 32'd0);
    chk("timeout_ldac_n", 32'(ldac_n), 32'd1);
    spi_en = 1'b1;
    request(1'b0, 12'h001, 16'h3001);
    drain("after_to_drain");
    chk("after_to_pulses", pulses - p0, 32'd1);
    chk("timeout_sticky", 32'(timeout_err), 32'd1);

    // Reset during WAIT_DONE.
    request(1'b0, 12'h222, 16'h3222);
    for (int i = 0; i < 60 && !spi_busy; i++) step();
    chk("wd_busy_seen", 32'(spi_busy), 32'd1);
    pulse_rst();
    #1;
    chk("wd_rst_start", 32'(spi_start), 32'd0);
    chk("wd_rst_ldac", 32'(ldac_n), 32'd1);
    chk("wd_rst_timeout", 32'(timeout_err), 32'd0);
    @(negedge clk); #2 rst = 1'b0;
    step();
    p0 = pulses;
    request(1'b1, 12'h333, 16'hB333);
    drain("wd_next_drain");
    chk("wd_next_pulses", pulses - p0, 32'd1);

    // Reset during LATCH.
    request(1'b0, 12'h444, 16'h3444);
    for (int i = 0; i < 80 && ldac_n; i++) @(negedge clk);
    chk("lt_ldac_low", 32'(ldac_n), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("lt_rst_ldac", 32'(ldac_n), 32'd1);
    chk("lt_rst_start", 32'(spi_start), 32'd0);
    @(negedge clk); #2 rst = 1'b0;
    step();
    p0 = pulses;
    request(1'b1, 12'h555, 16'hB555);
    drain("lt_next_drain");
    chk("lt_next_pulses", pulses - p0, 32'd1);

    // B raised while A is mid-transfer: B waits for A's latch to finish.
    p0 = pulses;
    request(1'b0, 12'h666, 16'h3666);
    for (int i = 0; i < 60 && !spi_busy; i++) step();
    chk("mid_busy_seen", 32'(spi_busy), 32'd1);
    request(1'b1, 12'h777, 16'hB777);
    drain("mid_drain");
    chk("mid_pulses", pulses - p0, 32'd2);
    chk("mid_b_after_latch", 32'(rise_at_ack_b > ack_a_cyc), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
